cart_rom_loader: RTL and testbench
==================================

Name: cart_rom_loader

Overview:
- Write-side counterpart of the cartridge mapper path. Mappers such as the Zemina 90-in-1 translate CPU reads into 27-bit memory addresses; this block is what places the ROM image at those addresses.
- It accepts the HPS download byte stream, buffers it in a small FIFO and writes each byte to cartridge memory through a req/ack handshake.
- Outputs: final image size, a completion pulse and an overflow flag, for use by block_info setup.

Parameters:
- BASE_ADDR, 27'h0000000: memory address of image byte 0.
- MAX_SIZE, 27'h0200000: image size limit in bytes (2 MiB).
- FIFO_DEPTH, 4: buffer entries; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  high for the duration of a download.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  27  byte offset within the image.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  backpressure to the HPS.
- mem_req  out  1  write request.
- mem_addr  out  27  write address.
- mem_din  out  8  write data.
- mem_ack  in  1  one-cycle completion of the current write.
- rom_size  out  27  highest accepted offset + 1.
- load_done  out  1  one-cycle pulse at end of load.
- overflow  out  1  sticky; an offset at or beyond MAX_SIZE was received.

Behaviour:
- Reset (asynchronous on reset_n low): every output is 0, the FIFO is empty, the FSM is in IDLE.
- FIFO entries are {offset[26:0], data[7:0]}.
  - Push when ioctl_download && ioctl_wr && !full && offset < MAX_SIZE.
  - Pop on mem_ack.
- ioctl_wait is registered. It equals (FIFO count >= FIFO_DEPTH-1), so a strobe arriving in the same cycle wait asserts still fits.
- If ioctl_wr arrives while the FIFO is full (protocol violation), the byte is dropped and overflow is set.
- If offset >= MAX_SIZE: the byte is dropped, overflow is set, rom_size is unchanged.
- rom_size: on every push, if offset+1 > rom_size then rom_size <= offset+1. Arithmetic is 27 bits; offset+1 cannot wrap because offset < MAX_SIZE.
- FSM states:
  - IDLE: a rising edge of ioctl_download clears rom_size and overflow and moves to LOAD.
  - LOAD: when the FIFO is non-empty and mem_req is low, present the head entry:
    - mem_addr = BASE_ADDR + offset, mod 2^27 (wraps silently);
    - mem_din = data;
    - mem_req = 1.
    This is registered, so mem_req rises 1 cycle after the push into an empty FIFO.
  - In LOAD, mem_req, mem_addr and mem_din stay stable until mem_ack. On mem_ack: pop the entry and drop mem_req. A new request may not be issued in the ack cycle, so back-to-back requests are separated by at least 1 idle cycle.
  - In LOAD, a falling edge of ioctl_download moves to DRAIN.
  - DRAIN: keep issuing writes until the FIFO is empty and mem_req is low, then go to DONE.
  - DONE: load_done = 1 for one cycle, then IDLE.
- mem_ack while mem_req is low is ignored.
- ioctl_wr while ioctl_download is low is ignored in every state.
- A rising edge of ioctl_download in DRAIN or DONE is not a restart. It is ignored until IDLE.
- Reset mid-write: mem_req drops asynchronously and the in-flight write is abandoned. Memory-side consistency is the memory controller's responsibility.
- rom_size and overflow hold their values after DONE until the next download starts.

Decomposition:
- Shared package (the existing mapper/cartridge package) holds:
  - the FSM state enum: LDR_IDLE, LDR_LOAD, LDR_DRAIN, LDR_DONE;
  - the loader_entry_t struct {logic [26:0] offset; logic [7:0] data;};
  - the 27-bit address width constant shared with mapper out.addr.
- Sub-module: loader_fifo. Synchronous single-clock FIFO.
  - Parameterised by DEPTH and entry type.
  - Provides push, pop, head, count, full and empty.
  - Same asynchronous active-low reset.

Test Plan:
- Basic load: download of bytes 0xA5 at offset 0 and 0x5A at offset 1, mem_ack 2 cycles after each req -> writes {0x0000000, A5} then {0x0000001, 5A}; rom_size = 2; load_done pulses once after ioctl_download falls; overflow = 0.
- Backpressure: mem_ack held low while 3 bytes stream at 1 per cycle -> ioctl_wait = 1 after the 3rd push; no byte lost; releasing ack drains offsets 0, 1, 2 in order.
- Overflow: MAX_SIZE = 16, byte at offset 16 -> no mem_req for it; overflow = 1; rom_size unchanged; overflow stays 1 after DONE and clears when the next download starts.
- Address translation: BASE_ADDR = 27'h7FFFFFF, offset 1 -> mem_addr = 27'h0000000 (wrap).
- End during pending writes: ioctl_download falls with 2 entries queued -> both written, then load_done; no load_done before the last ack.
- Reset mid-write: reset_n low while mem_req = 1 -> mem_req, rom_size, load_done and overflow all 0 immediately; FIFO empty; after reset release, a fresh download writes from offset 0 correctly.

Source files
------------

// File: rtl/cart_rom_loader_pkg.sv
// Shared cartridge types: loader FSM states, FIFO entry layout
// and the 27-bit memory address width also used by mapper out.addr.
package cart_rom_loader_pkg;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    LDR_IDLE,
    LDR_LOAD,
    LDR_DRAIN,
    LDR_DONE
  } ldr_state_e;

  typedef struct packed {
    logic [26:0] offset;
    logic [7:0]  data;
  } loader_entry_t;

  // Image offset to memory address; wraps mod 2^27.
  function automatic addr_t ldr_addr(
    input addr_t base,
    input addr_t off
  );
    return base + off;
  endfunction

endpackage

// File: rtl/cart_rom_loader_if.sv
// Cartridge memory write port: req/addr/din held until a one-cycle ack.
// master = loader side, slave = memory controller side.
interface cart_rom_loader_if;
  import cart_rom_loader_pkg::*;

  logic  mem_req;
  addr_t mem_addr;
  data_t mem_din;
  logic  mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_din,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_din,
    output mem_ack
  );

endinterface

// File: rtl/loader_fifo.sv
// Single-clock FIFO. Ports: push/din, pop, head, count, full, empty.
// DEPTH must be a power of two so the pointers wrap on their own.
module loader_fifo
  import cart_rom_loader_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = loader_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  entry_t        din,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_q];
  assign count   = cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/cart_rom_loader.sv
// HPS download -> FIFO -> cartridge memory writes; reports rom_size,
// load_done pulse and sticky overflow. Ports: clk, reset_n, ioctl_*, mem.
module cart_rom_loader
  import cart_rom_loader_pkg::*;
#(
  parameter addr_t BASE_ADDR  = 27'h0000000,
  parameter addr_t MAX_SIZE   = 27'h0200000,
  parameter int    FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     ioctl_download,
  input  logic     ioctl_wr,
  input  addr_t    ioctl_addr,
  input  data_t    ioctl_dout,
  output logic     ioctl_wait,
  cart_rom_loader_if.master mem,
  output addr_t    rom_size,
  output logic     load_done,
  output logic     overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ldr_state_e    state_q;
  ldr_state_e    state_d;
  logic          dl_q;
  logic          dl_rise;
  logic          dl_fall;
  logic          wr_seen;
  logic          in_range;
  logic          push;
  logic          pop;
  logic          issue;
  logic          start;
  logic          active;
  loader_entry_t fifo_din;
  loader_entry_t head;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic          full;
  logic          empty;
  addr_t         off_inc;
  addr_t         rom_size_d;
  logic          overflow_d;
  logic          mem_req_q;
  addr_t         mem_addr_q;
  data_t         mem_din_q;

  assign dl_rise  = ioctl_download & ~dl_q;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign wr_seen  = ioctl_download & ioctl_wr;
  assign in_range = (ioctl_addr < MAX_SIZE);
  assign push     = wr_seen & ~full & in_range;
  assign pop      = mem_req_q & mem.mem_ack;
  assign issue    = active & ~empty & ~mem_req_q;
  assign off_inc  = ioctl_addr + 1'b1;

  assign fifo_din.offset = ioctl_addr;
  assign fifo_din.data   = ioctl_dout;

  // Occupancy after this edge, so the registered wait
  // matches the FIFO it describes.
  assign count_nx = count + CW'(push) - CW'(pop);

  loader_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (loader_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (fifo_din),
    .pop     (pop),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= LDR_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    active    = 1'b0;
    load_done = 1'b0;
    unique case (state_q)
      LDR_IDLE: begin
        if (dl_rise) begin
          state_d = LDR_LOAD;
          start   = 1'b1;
        end
      end
      LDR_LOAD: begin
        active = 1'b1;
        if (dl_fall) state_d = LDR_DRAIN;
      end
      LDR_DRAIN: begin
        active = 1'b1;
        if (empty && !mem_req_q) state_d = LDR_DONE;
      end
      LDR_DONE: begin
        load_done = 1'b1;
        state_d   = LDR_IDLE;
      end
      default: state_d = LDR_IDLE;
    endcase
  end

  // Start-of-load clear comes first so a byte pushed
  // in the very first cycle still counts.
  always_comb begin
    rom_size_d = start ? '0 : rom_size;
    overflow_d = start ? 1'b0 : overflow;
    if (push && (off_inc > rom_size_d)) begin
      rom_size_d = off_inc;
    end
    if (wr_seen && (full || !in_range)) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_q       <= 1'b0;
      ioctl_wait <= 1'b0;
      rom_size   <= '0;
      overflow   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      dl_q       <= ioctl_download;
      ioctl_wait <= (count_nx >= CW'(FIFO_DEPTH - 1));
      rom_size   <= rom_size_d;
      overflow   <= overflow_d;
      if (pop) begin
        mem_req_q <= 1'b0;
      end else if (issue) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= ldr_addr(BASE_ADDR, head.offset);
        mem_din_q  <= head.data;
      end
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_din  = mem_din_q;

endmodule

// File: tb/tb_cart_rom_loader.sv
// Randomized bench for cart_rom_loader against a queue-based
// model of the image writes, rom_size and overflow.
module tb_cart_rom_loader;
  import cart_rom_loader_pkg::*;

  localparam addr_t BASE  = 27'h7FFFFFF;
  localparam addr_t MAXS  = 27'd16;
  localparam int    DEPTH = 4;

  typedef struct packed {
    addr_t a;
    data_t d;
  } wr_t;

  logic  clk = 1'b0;
  logic  reset_n = 1'b0;
  logic  ioctl_download = 1'b0;
  logic  ioctl_wr = 1'b0;
  addr_t ioctl_addr = '0;
  data_t ioctl_dout = '0;
  logic  ioctl_wait;
  addr_t rom_size;
  logic  load_done;
  logic  overflow;

  cart_rom_loader_if mem ();

  cart_rom_loader #(
    .BASE_ADDR  (BASE),
    .MAX_SIZE   (MAXS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem            (mem),
    .rom_size       (rom_size),
    .load_done      (load_done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  wr_t   exp_q[$];
  addr_t rom_m = '0;
  logic  ovf_m = 1'b0;
  int    done_cnt = 0;
  int    inflight = 0;
  bit    ack_en = 1'b0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Image model: in-range bytes become writes at BASE+off.
  task automatic model_byte(addr_t off, data_t d);
    wr_t w;
    if (off < MAXS) begin
      w.a = BASE + off;
      w.d = d;
      exp_q.push_back(w);
      if (off + 1 > rom_m) rom_m = off + 1;
    end else begin
      ovf_m = 1'b1;
    end
  endtask

  // Memory responder: checks each request, acks after 0..3 cycles.
  initial mem.mem_ack = 1'b0;
  always begin : resp
    wr_t w;
    int  dly;
    @(posedge clk);
    #1;
    if (ack_en && reset_n && mem.mem_req) begin
      inflight = 1;
      if (exp_q.size() == 0) begin
        chk("spurious_req", 0, 1);
        w.a = mem.mem_addr;
        w.d = mem.mem_din;
      end else begin
        w = exp_q.pop_front();
      end
      chk("wr_addr", mem.mem_addr, w.a);
      chk("wr_data", mem.mem_din, w.d);
      dly = $urandom_range(0, 3);
      repeat (dly) @(posedge clk);
      #1;
      chk("req_hold", {mem.mem_req, mem.mem_addr, mem.mem_din},
          {1'b1, w.a, w.d});
      mem.mem_ack = 1'b1;
      @(posedge clk);
      #1;
      mem.mem_ack = 1'b0;
      chk("req_gap", mem.mem_req, 0);
      inflight = 0;
    end
  end

  always @(negedge clk) begin
    if (load_done) begin
      done_cnt++;
      chk("done_pending", exp_q.size() + inflight, 0);
    end
  end

  task automatic start_dl();
    @(negedge clk);
    ioctl_download = 1'b1;
    rom_m = '0;
    ovf_m = 1'b0;
    @(negedge clk);
    chk("start_clear", {overflow, rom_size}, 0);
  endtask

  task automatic send(addr_t off, data_t d);
    int n = 0;
    @(negedge clk);
    while (ioctl_wait && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait_timeout", n, 0);
    ioctl_wr   = 1'b1;
    ioctl_addr = off;
    ioctl_dout = d;
    model_byte(off, d);
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl(string tag);
    int n = 0;
    int base = done_cnt;
    @(negedge clk);
    ioctl_download = 1'b0;
    while (done_cnt == base && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, done_cnt - base, 1);
    chk({tag, "_size"}, rom_size, rom_m);
    chk({tag, "_ovf"}, overflow, ovf_m);
    chk({tag, "_drained"}, exp_q.size() + inflight, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : main
    int base;
    int n;
    data_t d;

    #2;
    chk("rst_ctl", {ioctl_wait, mem.mem_req, load_done, overflow}, 0);
    chk("rst_size", rom_size, 0);
    chk("rst_bus", {mem.mem_addr, mem.mem_din}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    ack_en  = 1'b1;

    // basic two-byte load; BASE+1 wraps to 0
    start_dl();
    send(27'd0, 8'hA5);
    send(27'd1, 8'h5A);
    end_dl("basic");

    // strobe without download is ignored
    @(negedge clk);
    ioctl_wr   = 1'b1;
    ioctl_addr = 27'd3;
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("ign_req", mem.mem_req, 0);
    chk("ign_size", rom_size, rom_m);

    // backpressure: ack held, 5 strobes back to back
    ack_en = 1'b0;
    start_dl();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) chk("wait_after2", ioctl_wait, 0);
      if (i == 3) chk("wait_after3", ioctl_wait, 1);
      d = 8'($urandom);
      ioctl_wr   = 1'b1;
      ioctl_addr = addr_t'(i);
      ioctl_dout = d;
      if (i < DEPTH) model_byte(addr_t'(i), d);
      else ovf_m = 1'b1;
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("wait_full", ioctl_wait, 1);
    chk("bp_ovf", overflow, 1);
    ack_en = 1'b1;
    end_dl("bp");

    // out-of-range offsets
    start_dl();
    send(27'd3, 8'h11);
    send(27'd16, 8'h22);
    send(27'd15, 8'h33);
    end_dl("ovf");
    repeat (5) @(negedge clk);
    chk("ovf_sticky", overflow, 1);
    chk("size_hold", rom_size, 16);

    // download ends with writes pending
    ack_en = 1'b0;
    start_dl();
    send(27'd5, 8'h66);
    send(27'd9, 8'h99);
    base = done_cnt;
    @(negedge clk);
    ioctl_download = 1'b0;
    repeat (10) @(negedge clk);
    chk("early_done", done_cnt - base, 0);
    ack_en = 1'b1;
    end_dl("pend");

    // reset while a write is outstanding
    ack_en = 1'b0;
    start_dl();
    send(27'd7, 8'h77);
    n = 0;
    while (!mem.mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_req_seen", mem.mem_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid", {mem.mem_req, load_done, overflow, ioctl_wait}, 0);
    chk("rst_mid_size", rom_size, 0);
    exp_q.delete();
    rom_m = '0;
    ovf_m = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    ack_en  = 1'b1;
    start_dl();
    send(27'd0, 8'hC3);
    send(27'd1, 8'h3C);
    end_dl("post_rst");

    // randomized downloads
    for (int t = 0; t < 30; t++) begin
      start_dl();
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(addr_t'($urandom_range(0, 19)), 8'($urandom));
      end
      end_dl("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
